full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter REG_OUT, default 1, meaning: 1 = registered outputs with one-cycle latency, 0 = purely combinational outputs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  1  addend bit.
REQ-005 b  input  1  addend bit.
REQ-006 cin  input  1  carry-in bit.
REQ-007 in_valid  input  1  qualifies a/b/cin for capture.
REQ-008 s  output  1  sum bit.
REQ-009 cout  output  1  carry-out bit.
REQ-010 g  output  1  carry-generate, for use by a look-ahead carry unit.
REQ-011 p  output  1  carry-propagate, for use by a look-ahead carry unit.
REQ-012 out_valid  output  1  s/cout/g/p hold a result computed from a valid input.

Function
REQ-013 Sum SHALL be a XOR b XOR cin.
REQ-014 Carry-out SHALL be majority(a,b,cin) = (a AND b) OR (cin AND (a XOR b)).
REQ-015 g SHALL be a AND b; p SHALL be inclusive a OR b (not XOR); neither depends on cin.
REQ-016 Arithmetic invariant: 2*cout + s SHALL equal a + b + cin for all 8 input combinations.
REQ-017 REG_OUT=1: on a rising edge with in_valid=1 and rst=0, s/cout/g/p SHALL load the values of REQ-013..015; out_valid SHALL go 1 in the following cycle (latency exactly 1).
REQ-018 REG_OUT=1: on a rising edge with in_valid=0 and rst=0, s/cout/g/p SHALL hold their previous values and out_valid SHALL go 0.
REQ-019 REG_OUT=1: back-to-back valid inputs SHALL produce back-to-back results, one per cycle, no bubbles.
REQ-020 REG_OUT=0: s/cout/g/p SHALL follow the inputs combinationally in the same cycle; out_valid SHALL equal in_valid; clk/rst SHALL have no effect.
REQ-021 Outputs SHALL never carry X when a, b, cin are 0/1 and reset has been applied.

Reset
REQ-022 REG_OUT=1: while rst=1 at a rising edge, s, cout, g, p and out_valid SHALL all become 0.
REQ-023 rst SHALL take priority over in_valid; a result in flight when rst asserts SHALL be discarded, never presented.
REQ-024 First valid result after reset release SHALL appear one cycle after the first edge with rst=0 and in_valid=1.

Structure
REQ-025 No shared package is needed; REG_OUT is a module parameter only.
REQ-026 One sub-module, half_adder (x, y -> sum = x XOR y, carry = x AND y), SHALL be instantiated twice to form the sum/carry logic; g and p are computed in full_adder.
REQ-027 Output register stage SHALL be generated only when REG_OUT=1.
REQ-028 Block SHALL be instantiable four times in a ripple chain and as the sum cell of a 4-bit carry look-ahead adder (cout may be left unconnected).

Verification
REQ-029 Exhaustive: all 8 (a,b,cin) with in_valid=1, REG_OUT=1 -> next cycle 2*cout+s = a+b+cin, out_valid=1; e.g. 1,1,1 -> s=1, cout=1, g=1, p=1.
REQ-030 Propagate check: a=1,b=0,cin=1 -> s=0, cout=1, g=0, p=1; a=0,b=0,cin=1 -> s=1, cout=0, g=0, p=0.
REQ-031 Hold: valid 1,1,0 (s=0, cout=1) then in_valid=0 with inputs 0,0,1 -> s=0, cout=1 held, out_valid=0.
REQ-032 Reset mid-stream: valid 1,1,1 applied on the same edge as rst=1 -> s=cout=g=p=out_valid=0 next cycle; 1,0,0 next valid -> s=1, cout=0 one cycle later.
REQ-033 Back-to-back: valid 0,1,1 then 1,0,0 on consecutive cycles -> (s,cout) = (0,1) then (1,0), out_valid high both cycles.
REQ-034 REG_OUT=0: a=1,b=1,cin=0 -> s=0, cout=1, g=1, p=1 in same cycle, independent of clk/rst.

Source files
------------

// File: rtl/half_adder.sv
// Half adder: one XOR sum bit and one AND carry bit.
// Two instances form the full adder's sum/carry path.
module half_adder (
   input  logic x,
   input  logic y,
   output logic sum,
   output logic carry
);

   assign sum   = x ^ y;
   assign carry = x & y;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder with generate/propagate outputs for look-ahead carry use.
// REG_OUT=1 adds one output register stage; REG_OUT=0 is purely combinational.
module full_adder #(
   parameter int unsigned REG_OUT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic in_valid,
   output logic s,
   output logic cout,
   output logic g,
   output logic p,
   output logic out_valid
);

   logic ab_sum, ab_carry;
   logic sum_c, carry_c;
   logic fin_carry;
   logic g_c, p_c;

   half_adder u_ha_ab (
      .x     (a),
      .y     (b),
      .sum   (ab_sum),
      .carry (ab_carry)
   );

   half_adder u_ha_cin (
      .x     (ab_sum),
      .y     (cin),
      .sum   (sum_c),
      .carry (fin_carry)
   );

   assign carry_c = ab_carry | fin_carry;
   // p is inclusive OR so a look-ahead unit may use it for either carry form
   assign g_c     = a & b;
   assign p_c     = a | b;

   if (REG_OUT != 0) begin : g_reg
      logic s_q, cout_q, g_q, p_q, out_valid_q;
      logic s_d, cout_d, g_d, p_d, out_valid_d;

      always_comb begin
         s_d         = s_q;
         cout_d      = cout_q;
         g_d         = g_q;
         p_d         = p_q;
         out_valid_d = 1'b0;
         if (in_valid) begin
            s_d         = sum_c;
            cout_d      = carry_c;
            g_d         = g_c;
            p_d         = p_c;
            out_valid_d = 1'b1;
         end
      end

      // Reset wins over in_valid, so an in-flight result is dropped
      always_ff @(posedge clk) begin
         if (rst) begin
            s_q         <= 1'b0;
            cout_q      <= 1'b0;
            g_q         <= 1'b0;
            p_q         <= 1'b0;
            out_valid_q <= 1'b0;
         end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            g_q         <= g_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
         end
      end

      assign s         = s_q;
      assign cout      = cout_q;
      assign g         = g_q;
      assign p         = p_q;
      assign out_valid = out_valid_q;
   end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign s         = sum_c;
      assign cout      = carry_c;
      assign g         = g_c;
      assign p         = p_c;
      assign out_valid = in_valid;
   end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: arithmetic reference model with per-cycle compare,
// directed literal checks, and randomized stimulus for both output modes.
module tb_full_adder;

   logic clk = 1'b0;
   logic rst, a, b, cin, in_valid;
   logic r_s, r_cout, r_g, r_p, r_ov;
   logic c_s, c_cout, c_g, c_p, c_ov;

   int n_total = 0;
   int n_pass  = 0;

   // Model state {s, cout, g, p, out_valid} for the registered instance
   logic [4:0] mdl;
   bit         mdl_ok = 1'b0;

   always #5 clk = ~clk;

   full_adder #(.REG_OUT(1)) u_dut_reg (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .s         (r_s),
      .cout      (r_cout),
      .g         (r_g),
      .p         (r_p),
      .out_valid (r_ov)
   );

   full_adder #(.REG_OUT(0)) u_dut_comb (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .s         (c_s),
      .cout      (c_cout),
      .g         (c_g),
      .p         (c_p),
      .out_valid (c_ov)
   );

   // {s, cout, g, p} from integer addition
   function automatic logic [3:0] ref_fn(input logic ia, input logic ib, input logic ic);
      int total, ab;
      logic [3:0] r;
      total = int'(ia) + int'(ib) + int'(ic);
      ab    = int'(ia) + int'(ib);
      r[3]  = (total % 2) == 1;
      r[2]  = (total / 2) == 1;
      r[1]  = (ab == 2);
      r[0]  = (ab >= 1);
      return r;
   endfunction

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got s,cout,g,p,ov=%b expected %b at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         mdl    = 5'b0;
         mdl_ok = 1'b1;
      end else if (mdl_ok) begin
         if (in_valid) mdl = {ref_fn(a, b, cin), 1'b1};
         else          mdl[0] = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("reg_vs_model", {r_s, r_cout, r_g, r_p, r_ov}, mdl);
         chk("comb_vs_model", {c_s, c_cout, c_g, c_p, c_ov}, {ref_fn(a, b, cin), in_valid});
      end
   end

   task automatic step(input logic r, input logic v, input logic ia, input logic ib,
                       input logic ic);
      rst = r; in_valid = v; a = ia; b = ib; cin = ic;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset_state", {r_s, r_cout, r_g, r_p, r_ov}, 5'b00000);

      // All eight input combinations: 2*cout+s must equal the operand sum
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         step(0, 1, v[2], v[1], v[0]);
         chk("exhaustive_arith", {3'b000, r_cout, r_s},
             {3'b000, 2'(int'(v[2]) + int'(v[1]) + int'(v[0]))});
         chk("exhaustive_ov", {4'b0000, r_ov}, 5'b00001);
      end

      step(0, 1, 1, 1, 1);
      chk("all_ones", {r_s, r_cout, r_g, r_p, r_ov}, 5'b11111);
      step(0, 1, 1, 0, 1);
      chk("propagate_101", {r_s, r_cout, r_g, r_p, r_ov}, 5'b01011);
      step(0, 1, 0, 0, 1);
      chk("cin_only_001", {r_s, r_cout, r_g, r_p, r_ov}, 5'b10001);

      step(0, 1, 1, 1, 0);
      chk("hold_load_110", {r_s, r_cout, r_g, r_p, r_ov}, 5'b01111);
      step(0, 0, 0, 0, 1);
      chk("hold_invalid", {r_s, r_cout, r_g, r_p, r_ov}, 5'b01110);

      step(1, 1, 1, 1, 1);
      chk("reset_priority", {r_s, r_cout, r_g, r_p, r_ov}, 5'b00000);
      step(0, 1, 1, 0, 0);
      chk("after_reset_100", {r_s, r_cout, r_g, r_p, r_ov}, 5'b10011);

      step(0, 1, 0, 1, 1);
      chk("b2b_first_011", {r_s, r_cout, r_g, r_p, r_ov}, 5'b01011);
      step(0, 1, 1, 0, 0);
      chk("b2b_second_100", {r_s, r_cout, r_g, r_p, r_ov}, 5'b10011);

      // Combinational instance ignores rst and answers in the same cycle
      rst = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b0;
      #1;
      chk("comb_110_in_reset", {c_s, c_cout, c_g, c_p, c_ov}, 5'b01111);
      in_valid = 1'b0; a = 1'b1; b = 1'b0; cin = 1'b1;
      #1;
      chk("comb_101_invalid", {c_s, c_cout, c_g, c_p, c_ov}, 5'b01010);
      step(1, 0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom));
      end

      step(0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
